// File: rtl/mac_array.sv
// Output-stationary MAC array: A shifts east along rows, B shifts south down columns,
// each PE accumulates a_in*b_in. Define MAC_ARRAY_SATURATE_EN to clamp accumulators instead of wrapping.
module mac_array #(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
  parameter int                    M_ROWS     = 4,
  parameter int                    N_COLS     = M_ROWS
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [M_ROWS-1:0][DATA_WIDTH-1:0]          array_a_i,
  input  logic [N_COLS-1:0][DATA_WIDTH-1:0]          array_b_i,
  input  logic                                       feed_a_valid_i,
  input  logic                                       feed_b_valid_i,
  input  logic                                       a_clr_i,
  input  logic                                       b_clr_i,
  input  logic                                       acc_clr_i,
  output logic [M_ROWS*N_COLS-1:0][DATA_WIDTH-1:0]   array_out_o
);

  // Feeds have no back-pressure: a valid beat is consumed on the same rising edge.
  logic [DATA_WIDTH-1:0] a_w [M_ROWS][N_COLS];
  logic [DATA_WIDTH-1:0] b_w [M_ROWS][N_COLS];
  logic                  mac_en;

  assign mac_en = feed_a_valid_i & feed_b_valid_i;

  for (genvar i = 0; i < M_ROWS; i++) begin : g_row
    for (genvar j = 0; j < N_COLS; j++) begin : g_col
      logic [DATA_WIDTH-1:0] a_in, b_in, mac;
      logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;

      if (j == 0) begin : g_a_edge
        assign a_in = array_a_i[i];
      end else begin : g_a_link
        assign a_in = a_w[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_in = array_b_i[j];
      end else begin : g_b_link
        assign b_in = b_w[i-1][j];
      end

`ifdef MAC_ARRAY_SATURATE_EN
      logic [2*DATA_WIDTH-1:0] prod_full;
      logic [2*DATA_WIDTH:0]   sum_full;
      assign prod_full = {{DATA_WIDTH{1'b0}}, a_in} * {{DATA_WIDTH{1'b0}}, b_in};
      assign sum_full  = {1'b0, prod_full} + {{(DATA_WIDTH+1){1'b0}}, acc_q};
      assign mac = (|sum_full[2*DATA_WIDTH:DATA_WIDTH]) ? {DATA_WIDTH{1'b1}}
                                                        : sum_full[DATA_WIDTH-1:0];
`else
      logic [DATA_WIDTH-1:0] prod;
      assign prod = a_in * b_in;
      assign mac  = acc_q + prod;
`endif

      // Clears win over shift/accumulate only within their own register group.
      always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (a_clr_i)             a_d = '0;
        else if (feed_a_valid_i) a_d = a_in;
        if (b_clr_i)             b_d = '0;
        else if (feed_b_valid_i) b_d = b_in;
        if (acc_clr_i)           acc_d = '0;
        else if (mac_en)         acc_d = mac;
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          a_q   <= RESET_VAL;
          b_q   <= RESET_VAL;
          acc_q <= RESET_VAL;
        end else begin
          a_q   <= a_d;
          b_q   <= b_d;
          acc_q <= acc_d;
        end
      end

      assign a_w[i][j]                = a_q;
      assign b_w[i][j]                = b_q;
      assign array_out_o[i*N_COLS+j]  = acc_q;
    end
  end

endmodule

// File: tb/tb_mac_array.sv
// Directed and random bench for mac_array: a reference model pushes expected
// accumulator values into a queue each beat; they are popped and compared after the edge.
module tb_mac_array;
  localparam int W = 16;
  localparam int M = 4;
  localparam int N = 4;
  localparam int P = M * N;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic [M-1:0][W-1:0] array_a_i;
  logic [N-1:0][W-1:0] array_b_i;
  logic                feed_a_valid_i, feed_b_valid_i;
  logic                a_clr_i, b_clr_i, acc_clr_i;
  logic [P-1:0][W-1:0] array_out_o;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_a [M][N];
  logic [W-1:0] m_b [M][N];
  logic [W-1:0] m_acc [M][N];

  mac_array #(.DATA_WIDTH(W), .RESET_VAL('0), .M_ROWS(M), .N_COLS(N)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .array_a_i(array_a_i), .array_b_i(array_b_i),
    .feed_a_valid_i(feed_a_valid_i), .feed_b_valid_i(feed_b_valid_i),
    .a_clr_i(a_clr_i), .b_clr_i(b_clr_i), .acc_clr_i(acc_clr_i),
    .array_out_o(array_out_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Next-state model evaluated from the inputs currently on the pins.
  task automatic model_step();
    logic [W-1:0] na [M][N];
    logic [W-1:0] nb [M][N];
    logic [W-1:0] nacc [M][N];
    logic [W-1:0] ai, bi;
    logic [2*W:0] full;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) ai = array_a_i[i]; else ai = m_a[i][j-1];
        if (i == 0) bi = array_b_i[j]; else bi = m_b[i-1][j];
        na[i][j]   = a_clr_i ? '0 : (feed_a_valid_i ? ai : m_a[i][j]);
        nb[i][j]   = b_clr_i ? '0 : (feed_b_valid_i ? bi : m_b[i][j]);
        full       = (2*W+1)'(ai) * (2*W+1)'(bi) + (2*W+1)'(m_acc[i][j]);
`ifdef MAC_ARRAY_SATURATE_EN
        if (full > (2*W+1)'(65535)) full = (2*W+1)'(65535);
`endif
        nacc[i][j] = acc_clr_i ? '0 :
                     ((feed_a_valid_i && feed_b_valid_i) ? full[W-1:0] : m_acc[i][j]);
        if (rst_i) begin
          na[i][j] = '0; nb[i][j] = '0; nacc[i][j] = '0;
        end
      end
    end
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        m_a[i][j]   = na[i][j];
        m_b[i][j]   = nb[i][j];
        m_acc[i][j] = nacc[i][j];
        exp_q.push_back(nacc[i][j]);
      end
    end
  endtask

  task automatic step(input string tag, input logic r, input logic va, input logic vb,
                      input logic ca, input logic cb, input logic cc);
    logic [W-1:0] e;
    rst_i = r; feed_a_valid_i = va; feed_b_valid_i = vb;
    a_clr_i = ca; b_clr_i = cb; acc_clr_i = cc;
    model_step();
    @(posedge clk_i);
    #1;
    for (int k = 0; k < P; k++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_queue_empty"}, 16'd1, 16'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s[%0d]", tag, k), array_out_o[k], e);
      end
    end
  endtask

  task automatic set_all(input logic [W-1:0] av, input logic [W-1:0] bv);
    for (int i = 0; i < M; i++) array_a_i[i] = av;
    for (int j = 0; j < N; j++) array_b_i[j] = bv;
  endtask

  initial begin
    set_all('0, '0);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        m_a[i][j] = 'x; m_b[i][j] = 'x; m_acc[i][j] = 'x;
      end

    // reset, then one idle cycle still at reset value
    step("reset", 1, 1, 1, 0, 0, 0);
    step("reset2", 1, 0, 0, 0, 0, 0);
    step("post_reset", 0, 0, 0, 0, 0, 0);

    // single beat a=[1,2,3,4], b=[5,6,7,8]
    for (int i = 0; i < M; i++) array_a_i[i] = W'(i + 1);
    for (int j = 0; j < N; j++) array_b_i[j] = W'(j + 5);
    step("one_beat", 0, 1, 1, 0, 0, 0);
    check("one_beat_pe00", array_out_o[0], 16'd5);
    check("one_beat_pe01", array_out_o[1], 16'd0);

    // all ones for 4 beats then 5 idle cycles
    step("rst_b", 1, 0, 0, 0, 0, 0);
    set_all(16'd1, 16'd1);
    for (int t = 0; t < 4; t++) step("ones_beat", 0, 1, 1, 0, 0, 0);
    for (int t = 0; t < 5; t++) step("ones_idle", 0, 0, 0, 0, 0, 0);
    check("ones_pe00", array_out_o[0], 16'd4);
    check("ones_pe12", array_out_o[1*N+2], 16'd2);
    check("ones_pe33", array_out_o[3*N+3], 16'd1);

    // acc clear alongside a valid beat, then a clear, then a probing beat
    step("acc_clr", 0, 1, 1, 0, 0, 1);
    check("acc_clr_pe00", array_out_o[0], 16'd0);
    step("a_clr", 0, 0, 0, 1, 0, 0);
    step("after_a_clr", 0, 1, 1, 0, 0, 0);
    check("after_a_clr_pe00", array_out_o[0], 16'd1);
    check("after_a_clr_pe01", array_out_o[1], 16'd0);

    // overflow boundary
    step("rst_c", 1, 0, 0, 0, 0, 0);
    set_all(16'd256, 16'd256);
    step("ovf", 0, 1, 1, 0, 0, 0);
`ifdef MAC_ARRAY_SATURATE_EN
    check("ovf_pe00", array_out_o[0], 16'd65535);
`else
    check("ovf_pe00", array_out_o[0], 16'd0);
`endif

    // reset mid-run, then repeat the all-ones run
    step("rst_d", 1, 0, 0, 0, 0, 0);
    set_all(16'd1, 16'd1);
    step("mid_beat", 0, 1, 1, 0, 0, 0);
    step("mid_beat", 0, 1, 1, 0, 0, 0);
    step("mid_rst", 1, 1, 1, 0, 0, 0);
    check("mid_rst_pe00", array_out_o[0], 16'd0);
    for (int t = 0; t < 4; t++) step("rerun_beat", 0, 1, 1, 0, 0, 0);
    for (int t = 0; t < 5; t++) step("rerun_idle", 0, 0, 0, 0, 0, 0);
    check("rerun_pe00", array_out_o[0], 16'd4);
    check("rerun_pe12", array_out_o[1*N+2], 16'd2);
    check("rerun_pe33", array_out_o[3*N+3], 16'd1);

    // A-only shifting: accumulators hold, then a beat exposes shifted A and held B
    for (int i = 0; i < M; i++) array_a_i[i] = W'(10 + i);
    step("a_only", 0, 1, 0, 0, 0, 0);
    step("a_only", 0, 1, 0, 0, 0, 0);
    check("a_only_pe00", array_out_o[0], 16'd4);
    for (int i = 0; i < M; i++) array_a_i[i] = W'(20 + i);
    set_all(16'd0, 16'd3);
    step("a_only_probe", 0, 1, 1, 0, 0, 0);
    check("a_only_probe_pe02", array_out_o[2], 16'd32);

    // random traffic
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < M; i++) array_a_i[i] = W'($urandom_range(0, 65535));
      for (int j = 0; j < N; j++) array_b_i[j] = W'($urandom_range(0, 65535));
      step("rand", ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=%0d expected=%0d", checks, 0);
    $fatal(1, "timeout");
  end
endmodule
